rv_desh: RTL and testbench
==========================

RV_DESH -- requirements
Module: rv_desh

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst_n  input  1  asynchronous, active-low reset.
REQ-003 inst  input  32  RV32I/Zicsr instruction word, sampled every rising clk edge.
REQ-004 opcode  output  7  registered inst[6:0], always passed through ungated.
REQ-005 rs1 / rs1_en  output  5 / 1  source-1 index inst[19:15] and its valid flag.
REQ-006 rs2 / rs2_en  output  5 / 1  source-2 index inst[24:20] and its valid flag.
REQ-007 rd / rd_en  output  5 / 1  destination index inst[11:7] and register-write flag.
REQ-008 funct3 / f3_en  output  3 / 1  inst[14:12] and its valid flag.
REQ-009 funct7 / f7_en  output  7 / 1  inst[31:25] and its valid flag.
REQ-010 mem_en, mem_wr  output  1 each  memory access flag; store flag.
REQ-011 csr_en, csr_wr  output  1 each  CSR access flag; CSR write flag.
REQ-012 pc_load  output  1  control-transfer flag (PC may be loaded).
REQ-013 illegal  output  1  unrecognised encoding; port order: clk, rst_n, inst, then REQ-004..REQ-012 outputs in listed order, illegal last.

Function
REQ-014 Decoder is registered: every output reflects the inst sampled at the previous rising edge (latency 1 cycle, no stall, no handshake).
REQ-015 Each field output (rs1, rs2, rd, funct3, funct7) SHALL be zero when its enable is 0, else the raw field.
REQ-016 Flags not listed for an opcode below SHALL be 0.
REQ-017 LUI 0110111, AUIPC 0010111: rd_en.
REQ-018 JAL 1101111: rd_en, pc_load.
REQ-019 JALR 1100111: rs1_en, rd_en, f3_en, pc_load.
REQ-020 BRANCH 1100011: rs1_en, rs2_en, f3_en, pc_load.
REQ-021 LOAD 0000011: rs1_en, rd_en, f3_en, mem_en.
REQ-022 STORE 0100011: rs1_en, rs2_en, f3_en, mem_en, mem_wr.
REQ-023 OP-IMM 0010011: rs1_en, rd_en, f3_en; f7_en additionally when funct3 is 001 or 101 (shifts).
REQ-024 OP 0110011: rs1_en, rs2_en, rd_en, f3_en, f7_en.
REQ-025 MISC-MEM 0001111: f3_en only.
REQ-026 SYSTEM 1110011, funct3=000 (ECALL/EBREAK/xRET): f3_en only.
REQ-027 SYSTEM, funct3!=000: csr_en, rd_en, f3_en; rs1_en when funct3[2]=0; csr_wr when funct3[1:0]=01, or when inst[19:15]!=0.
REQ-028 Any other opcode, including inst[1:0]!=11: illegal=1, all other flags 0; opcode still passed through.
REQ-029 No flag SHALL depend on rd=x0; writes to x0 are filtered downstream.

Reset
REQ-030 While rst_n=0 every output, including opcode and illegal, SHALL be 0, asynchronously.
REQ-031 First rising edge with rst_n=1 decodes the inst present at that edge; reset asserted mid-stream clears outputs immediately.

Verification
REQ-032 inst=0x000050B7 -> next cycle opcode=0110111, rd=1, rd_en=1, all other flags 0.
REQ-033 inst=0x00508193 -> rs1=1, rd=3, funct3=0, rs1_en/rd_en/f3_en=1, f7_en=0; inst=0x00C0D093 -> funct3=101, f7_en=1, funct7=0.
REQ-034 inst=0x00502083 -> rs1=0, rd=1, funct3=010, mem_en=1, mem_wr=0; inst=0x00112223 (sw) -> mem_en=1, mem_wr=1, rd_en=0.
REQ-035 inst=0xFE000CE3 -> opcode=1100011, rs1_en/rs2_en/f3_en/pc_load=1, rd_en=0; inst=0xFF9FF2EF -> rd=5, rd_en=1, pc_load=1.
REQ-036 inst=0x30029073 (csrrw) -> csr_en=1, csr_wr=1, rs1_en=1; inst=0x30002073 (csrrs x0) -> csr_wr=0; inst=0x00000000 -> illegal=1.
REQ-037 Assert rst_n=0 between clock edges while outputs non-zero -> all outputs 0 without waiting for clk.

Source files
------------

// File: rtl/rv_desh.sv
// Registered RV32I/Zicsr instruction field decoder: raw fields, per-field
// valid flags and coarse control flags, one cycle after the instruction.
module rv_desh (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] inst,
  output logic [6:0]  opcode,
  output logic [4:0]  rs1,
  output logic        rs1_en,
  output logic [4:0]  rs2,
  output logic        rs2_en,
  output logic [4:0]  rd,
  output logic        rd_en,
  output logic [2:0]  funct3,
  output logic        f3_en,
  output logic [6:0]  funct7,
  output logic        f7_en,
  output logic        mem_en,
  output logic        mem_wr,
  output logic        csr_en,
  output logic        csr_wr,
  output logic        pc_load,
  output logic        illegal
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_MISC   = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  logic d_rs1_en, d_rs2_en, d_rd_en, d_f3_en, d_f7_en;
  logic d_mem_en, d_mem_wr, d_csr_en, d_csr_wr, d_pc_load, d_illegal;

  always_comb begin
    d_rs1_en  = 1'b0;
    d_rs2_en  = 1'b0;
    d_rd_en   = 1'b0;
    d_f3_en   = 1'b0;
    d_f7_en   = 1'b0;
    d_mem_en  = 1'b0;
    d_mem_wr  = 1'b0;
    d_csr_en  = 1'b0;
    d_csr_wr  = 1'b0;
    d_pc_load = 1'b0;
    d_illegal = 1'b0;
    case (inst[6:0])
      OP_LUI, OP_AUIPC: d_rd_en = 1'b1;
      OP_JAL: begin
        d_rd_en   = 1'b1;
        d_pc_load = 1'b1;
      end
      OP_JALR: begin
        d_rs1_en  = 1'b1;
        d_rd_en   = 1'b1;
        d_f3_en   = 1'b1;
        d_pc_load = 1'b1;
      end
      OP_BRANCH: begin
        d_rs1_en  = 1'b1;
        d_rs2_en  = 1'b1;
        d_f3_en   = 1'b1;
        d_pc_load = 1'b1;
      end
      OP_LOAD: begin
        d_rs1_en = 1'b1;
        d_rd_en  = 1'b1;
        d_f3_en  = 1'b1;
        d_mem_en = 1'b1;
      end
      OP_STORE: begin
        d_rs1_en = 1'b1;
        d_rs2_en = 1'b1;
        d_f3_en  = 1'b1;
        d_mem_en = 1'b1;
        d_mem_wr = 1'b1;
      end
      OP_IMM: begin
        d_rs1_en = 1'b1;
        d_rd_en  = 1'b1;
        d_f3_en  = 1'b1;
        // Only the shift forms carry a meaningful funct7 (shamt qualifier).
        d_f7_en  = (inst[13:12] == 2'b01);
      end
      OP_OP: begin
        d_rs1_en = 1'b1;
        d_rs2_en = 1'b1;
        d_rd_en  = 1'b1;
        d_f3_en  = 1'b1;
        d_f7_en  = 1'b1;
      end
      OP_MISC: d_f3_en = 1'b1;
      OP_SYSTEM: begin
        d_f3_en = 1'b1;
        if (inst[14:12] != 3'b000) begin
          d_csr_en = 1'b1;
          d_rd_en  = 1'b1;
          d_rs1_en = ~inst[14];
          // Set/clear forms with a zero source (x0 or uimm=0) only read the CSR.
          d_csr_wr = (inst[13:12] == 2'b01) || (inst[19:15] != 5'd0);
        end
      end
      default: d_illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opcode  <= '0;
      rs1     <= '0;
      rs1_en  <= 1'b0;
      rs2     <= '0;
      rs2_en  <= 1'b0;
      rd      <= '0;
      rd_en   <= 1'b0;
      funct3  <= '0;
      f3_en   <= 1'b0;
      funct7  <= '0;
      f7_en   <= 1'b0;
      mem_en  <= 1'b0;
      mem_wr  <= 1'b0;
      csr_en  <= 1'b0;
      csr_wr  <= 1'b0;
      pc_load <= 1'b0;
      illegal <= 1'b0;
    end else begin
      opcode  <= inst[6:0];
      rs1     <= d_rs1_en ? inst[19:15] : 5'd0;
      rs1_en  <= d_rs1_en;
      rs2     <= d_rs2_en ? inst[24:20] : 5'd0;
      rs2_en  <= d_rs2_en;
      rd      <= d_rd_en ? inst[11:7] : 5'd0;
      rd_en   <= d_rd_en;
      funct3  <= d_f3_en ? inst[14:12] : 3'd0;
      f3_en   <= d_f3_en;
      funct7  <= d_f7_en ? inst[31:25] : 7'd0;
      f7_en   <= d_f7_en;
      mem_en  <= d_mem_en;
      mem_wr  <= d_mem_wr;
      csr_en  <= d_csr_en;
      csr_wr  <= d_csr_wr;
      pc_load <= d_pc_load;
      illegal <= d_illegal;
    end
  end

endmodule

// File: tb/tb_rv_desh.sv
// Scoreboard bench for rv_desh: directed encodings, randomized decode against
// a flag-table reference model, and asynchronous reset behaviour.
module tb_rv_desh;

  typedef struct packed {
    logic [6:0] opcode;
    logic [4:0] rs1;
    logic       rs1_en;
    logic [4:0] rs2;
    logic       rs2_en;
    logic [4:0] rd;
    logic       rd_en;
    logic [2:0] funct3;
    logic       f3_en;
    logic [6:0] funct7;
    logic       f7_en;
    logic       mem_en;
    logic       mem_wr;
    logic       csr_en;
    logic       csr_wr;
    logic       pc_load;
    logic       illegal;
  } exp_t;

  localparam logic [9:0] R1  = 10'b10_0000_0000;
  localparam logic [9:0] R2  = 10'b01_0000_0000;
  localparam logic [9:0] RD  = 10'b00_1000_0000;
  localparam logic [9:0] F3  = 10'b00_0100_0000;
  localparam logic [9:0] F7  = 10'b00_0010_0000;
  localparam logic [9:0] MEM = 10'b00_0001_0000;
  localparam logic [9:0] MW  = 10'b00_0000_1000;
  localparam logic [9:0] CSR = 10'b00_0000_0100;
  localparam logic [9:0] CW  = 10'b00_0000_0010;
  localparam logic [9:0] PC  = 10'b00_0000_0001;

  logic        clk;
  logic        rst_n;
  logic [31:0] inst;
  logic [6:0]  opcode;
  logic [4:0]  rs1, rs2, rd;
  logic        rs1_en, rs2_en, rd_en, f3_en, f7_en;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic        mem_en, mem_wr, csr_en, csr_wr, pc_load, illegal;

  exp_t act;
  exp_t q[$];
  logic [31:0] inst_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b1;

  rv_desh dut (
    .clk(clk), .rst_n(rst_n), .inst(inst),
    .opcode(opcode), .rs1(rs1), .rs1_en(rs1_en), .rs2(rs2), .rs2_en(rs2_en),
    .rd(rd), .rd_en(rd_en), .funct3(funct3), .f3_en(f3_en),
    .funct7(funct7), .f7_en(f7_en), .mem_en(mem_en), .mem_wr(mem_wr),
    .csr_en(csr_en), .csr_wr(csr_wr), .pc_load(pc_load), .illegal(illegal)
  );

  assign act = {opcode, rs1, rs1_en, rs2, rs2_en, rd, rd_en, funct3, f3_en,
                funct7, f7_en, mem_en, mem_wr, csr_en, csr_wr, pc_load, illegal};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t build(input logic [6:0] op, input logic [31:0] i,
                                 input logic [9:0] f, input logic ill);
    exp_t e;
    e.opcode  = op;
    e.rs1_en  = (f & R1) != 0;
    e.rs2_en  = (f & R2) != 0;
    e.rd_en   = (f & RD) != 0;
    e.f3_en   = (f & F3) != 0;
    e.f7_en   = (f & F7) != 0;
    e.rs1     = e.rs1_en ? i[19:15] : 5'd0;
    e.rs2     = e.rs2_en ? i[24:20] : 5'd0;
    e.rd      = e.rd_en  ? i[11:7]  : 5'd0;
    e.funct3  = e.f3_en  ? i[14:12] : 3'd0;
    e.funct7  = e.f7_en  ? i[31:25] : 7'd0;
    e.mem_en  = (f & MEM) != 0;
    e.mem_wr  = (f & MW) != 0;
    e.csr_en  = (f & CSR) != 0;
    e.csr_wr  = (f & CW) != 0;
    e.pc_load = (f & PC) != 0;
    e.illegal = ill;
    return e;
  endfunction

  // Reference: a table of which flags each instruction class owns.
  function automatic exp_t model(input logic [31:0] i);
    logic [9:0] f;
    logic       ill;
    f   = '0;
    ill = 1'b0;
    case (i[6:0])
      7'b0110111, 7'b0010111: f = RD;
      7'b1101111: f = RD | PC;
      7'b1100111: f = R1 | RD | F3 | PC;
      7'b1100011: f = R1 | R2 | F3 | PC;
      7'b0000011: f = R1 | RD | F3 | MEM;
      7'b0100011: f = R1 | R2 | F3 | MEM | MW;
      7'b0010011: f = R1 | RD | F3 | ((i[14:12] == 3'd1 || i[14:12] == 3'd5) ? F7 : 10'd0);
      7'b0110011: f = R1 | R2 | RD | F3 | F7;
      7'b0001111: f = F3;
      7'b1110011: begin
        if (i[14:12] == 3'd0) f = F3;
        else begin
          f = CSR | RD | F3;
          if (i[14] == 1'b0) f = f | R1;
          if (i[13:12] == 2'b01 || i[19:15] != 5'd0) f = f | CW;
        end
      end
      default: ill = 1'b1;
    endcase
    return build(i[6:0], i, f, ill);
  endfunction

  // Hand-derived expectation: explicit field values plus flag set.
  function automatic exp_t mk(input logic [6:0] op, input logic [4:0] r1, input logic [4:0] r2,
                              input logic [4:0] rdv, input logic [2:0] f3, input logic [6:0] f7,
                              input logic [9:0] f, input logic ill);
    logic [31:0] raw;
    raw = {f7, r2, r1, f3, rdv, 7'd0};
    return build(op, raw, f, ill);
  endfunction

  task automatic applyStimulus(input logic [31:0] x, input exp_t e);
    @(negedge clk);
    inst = x;
    q.push_back(e);
    inst_q.push_back(x);
  endtask

  task automatic checkOutput(input string name, input exp_t got, input exp_t want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s: got=%h want=%h", name, got, want);
    end
  endtask

  // Monitor: the decoder presents a new result every cycle, one cycle late.
  always @(posedge clk) begin
    #1;
    if (mon_en && q.size() > 0) begin
      exp_t e;
      logic [31:0] x;
      e = q.pop_front();
      x = inst_q.pop_front();
      checkOutput($sformatf("decode inst=%h", x), act, e);
    end
  end

  task automatic drain();
    int n;
    n = 0;
    while (q.size() > 0 && n < 5) begin
      @(posedge clk);
      n++;
    end
    #2;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: got=%0d pending want=0", q.size());
    end
  endtask

  initial begin
    logic [6:0]  legal[11];
    logic [31:0] r;
    logic [6:0]  op;
    legal = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0F, 7'h73};

    rst_n = 1'b0;
    inst  = 32'h00C0D093;
    #1;
    checkOutput("reset_initial", act, '0);
    repeat (3) @(posedge clk);
    #2;
    checkOutput("reset_hold", act, '0);
    rst_n = 1'b1;

    applyStimulus(32'h000050B7, mk(7'h37, 5'd0, 5'd0, 5'd1, 3'd0, 7'd0, RD, 1'b0));
    applyStimulus(32'h00508193, mk(7'h13, 5'd1, 5'd0, 5'd3, 3'd0, 7'd0, R1 | RD | F3, 1'b0));
    applyStimulus(32'h00C0D093, mk(7'h13, 5'd1, 5'd0, 5'd1, 3'b101, 7'd0, R1 | RD | F3 | F7, 1'b0));
    applyStimulus(32'h00502083, mk(7'h03, 5'd0, 5'd0, 5'd1, 3'b010, 7'd0, R1 | RD | F3 | MEM, 1'b0));
    applyStimulus(32'h00112223, mk(7'h23, 5'd2, 5'd1, 5'd0, 3'b010, 7'd0, R1 | R2 | F3 | MEM | MW, 1'b0));
    applyStimulus(32'hFE000CE3, mk(7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, R1 | R2 | F3 | PC, 1'b0));
    applyStimulus(32'hFF9FF2EF, mk(7'h6F, 5'd0, 5'd0, 5'd5, 3'd0, 7'd0, RD | PC, 1'b0));
    applyStimulus(32'h30029073, mk(7'h73, 5'd5, 5'd0, 5'd0, 3'b001, 7'd0, R1 | RD | F3 | CSR | CW, 1'b0));
    applyStimulus(32'h30002073, mk(7'h73, 5'd0, 5'd0, 5'd0, 3'b010, 7'd0, R1 | RD | F3 | CSR, 1'b0));
    applyStimulus(32'h3002E073, mk(7'h73, 5'd0, 5'd0, 5'd0, 3'b110, 7'd0, RD | F3 | CSR | CW, 1'b0));
    applyStimulus(32'h00000073, mk(7'h73, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, F3, 1'b0));
    applyStimulus(32'h40B50533, mk(7'h33, 5'd10, 5'd11, 5'd10, 3'd0, 7'h20, R1 | R2 | RD | F3 | F7, 1'b0));
    applyStimulus(32'h00000000, mk(7'h00, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 10'd0, 1'b1));
    applyStimulus(32'h00000036, mk(7'h36, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 10'd0, 1'b1));
    applyStimulus(32'h0000000F, mk(7'h0F, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, F3, 1'b0));

    for (int k = 0; k < 200; k++) begin
      r = $urandom();
      if ($urandom_range(0, 9) < 8) op = legal[$urandom_range(0, 10)];
      else op = r[6:0];
      r = {r[31:7], op};
      applyStimulus(r, model(r));
    end
    drain();

    applyStimulus(32'hFF9FF2EF, mk(7'h6F, 5'd0, 5'd0, 5'd5, 3'd0, 7'd0, RD | PC, 1'b0));
    @(posedge clk);
    #3;
    mon_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    checkOutput("async_clear", act, '0);
    q.delete();
    inst_q.delete();
    @(posedge clk);
    #2;
    checkOutput("reset_midstream_hold", act, '0);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    applyStimulus(32'h00112223, mk(7'h23, 5'd2, 5'd1, 5'd0, 3'b010, 7'd0, R1 | R2 | F3 | MEM | MW, 1'b0));
    applyStimulus(32'h30029073, mk(7'h73, 5'd5, 5'd0, 5'd0, 3'b001, 7'd0, R1 | RD | F3 | CSR | CW, 1'b0));
    applyStimulus(32'h00000000, mk(7'h00, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 10'd0, 1'b1));
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
